alua_seq: RTL and testbench
===========================

ALUA_SEQ -- requirements
Module: alua_seq

Interface
REQ-001 The block SHALL have these ports, one per line: name  direction  width  meaning.
- clkc  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- dec_vld  in  1  decode presents an ALU-A source select this cycle.
- dec_sel  in  4  encoded source: 0 ONE, 1 M1, 2 M2, 3 HL, 4 IX, 5 IY, 6 PC, 7 AA, 8 BIT, 9 DAA, 10 II, 11 RR, 12 INT, 13 RST, 14-15 NONE.
- wait_st  in  1  pipeline stall; freezes all state.
- int_ack  in  1  one-cycle pulse that starts the interrupt vector sequence.
- rst_op  in  1  sampled with int_ack; 1 selects the RST vector, 0 selects the INT vector.
- alua_reg  out  `ALUA_IDX+1 (14)  registered one-hot ALU-A select, bit n = encoded n.
- seq_busy  out  1  interrupt sequence in progress; decode must hold.
- sel_err  out  1  sticky one-hot violation flag; present only when ALUA_CHK_EN is defined.
REQ-002 Clock and reset SHALL be exactly as decided: one clock clkc; reset synchronous and active-high.

Function
REQ-003 alua_reg SHALL be registered with 1-cycle latency from dec_vld/dec_sel.
REQ-004 In state IDLE with dec_vld=1 and wait_st=0, alua_reg SHALL load onehot(dec_sel); dec_sel 14-15 SHALL load all-zero.
REQ-005 In IDLE with dec_vld=0 and wait_st=0, alua_reg SHALL load all-zero.
REQ-006 While wait_st=1, alua_reg, state, and the latched vector type SHALL hold, and int_ack SHALL be ignored.
REQ-007 The FSM SHALL have four states: IDLE, PUSH, PCSEL, VEC; it resets to IDLE.
REQ-008 IDLE→PUSH on int_ack=1 and wait_st=0; on the same edge alua_reg SHALL load AA_M2 and rst_op SHALL be latched.
REQ-009 PUSH→PCSEL on wait_st=0; on the same edge alua_reg SHALL load AA_PC.
REQ-010 PCSEL→VEC on wait_st=0; on the same edge alua_reg SHALL load AA_RST if latched rst_op=1, else AA_INT.
REQ-011 VEC→IDLE on wait_st=0; on that edge the normal IDLE load rule SHALL apply (REQ-004/005).
REQ-012 seq_busy SHALL be a registered output, equal to 1 exactly when state is PUSH, PCSEL or VEC.
REQ-013 int_ack and dec_vld in the same IDLE cycle: int_ack SHALL win and the decode select SHALL be dropped; decode is responsible for re-presenting it.
REQ-014 dec_vld SHALL be ignored while seq_busy=1.
REQ-015 int_ack SHALL be ignored while seq_busy=1; no re-entry or queuing.
REQ-016 alua_reg SHALL never have more than one bit set.

Reset
REQ-017 While reset=1: state=IDLE, alua_reg=0, seq_busy=0, latched rst_op=0, sel_err=0 (when present).
REQ-018 Reset SHALL take priority over wait_st and int_ack.
REQ-019 Reset during an interrupt sequence SHALL abort it; the first cycle after reset is IDLE with outputs 0.

Configuration
REQ-020 Macro ALUA_CHK_EN defined: sel_err is present; it SHALL set on any edge where the next alua_reg has popcount >1 and stay set until reset.
REQ-021 Macro ALUA_CHK_EN undefined: the sel_err port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-022 The shared package/defines file SHALL hold:
- `ALUA_IDX;
- AA_ONE..AA_RST bit positions;
- the 4-bit source encodings;
- the FSM state encodings.
REQ-023 The onehot(dec_sel) decoder SHALL be a sub-module alua_dec, purely combinational, 4→14.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Decode issue: reset, then dec_vld=1, dec_sel=3 → next cycle alua_reg=0x0008, seq_busy=0.
- Stall hold: dec_sel=4 issued, then wait_st=1 for 3 cycles with dec_sel=5 → alua_reg stays 0x0010 for all 3 cycles, then 0x0020 one cycle after wait_st=0.
- INT sequence: int_ack=1, rst_op=0 → alua_reg 0x0004, 0x0040, 0x1000 on consecutive cycles; seq_busy=1 for 3 cycles.
- RST vs collision: int_ack=1, rst_op=1, dec_vld=1, dec_sel=7 in the same cycle → sequence ends in 0x2000; 0x0080 never appears.
- Abort: reset asserted while in PCSEL → next cycle alua_reg=0, seq_busy=0; a later int_ack restarts at 0x0004.
- Checker (ALUA_CHK_EN defined): force a two-hot alua_reg → sel_err=1 and stays set until reset.

Source files
------------

// File: rtl/alua_seq_pkg.sv
// -----------------------------------------------------------------------------
// alua_seq_pkg -- shared definitions for the ALU-A source sequencer.
//
// Holds:
//   `ALUA_IDX      index of the highest ALU-A select bit (13 -> 14-bit select)
//   ALUA_W         width of the one-hot select vector
//   AA_*           bit positions in the one-hot ALU-A select
//   alua_src_e     4-bit encoded source select presented by decode
//   alua_state_e   interrupt-sequence FSM states
//   aa_bit()       one-hot vector with a single AA_* position set
//   multi_hot()    true when a select vector has more than one bit set
// -----------------------------------------------------------------------------
`ifndef ALUA_IDX
`define ALUA_IDX 13
`endif

package alua_seq_pkg;

  localparam int ALUA_W = `ALUA_IDX + 1;

  // Bit positions in the one-hot ALU-A select (bit n == encoded source n).
  localparam int AA_ONE  = 0;
  localparam int AA_M1   = 1;
  localparam int AA_M2   = 2;
  localparam int AA_HL   = 3;
  localparam int AA_IX   = 4;
  localparam int AA_IY   = 5;
  localparam int AA_PC   = 6;
  localparam int AA_AA   = 7;
  localparam int AA_BIT  = 8;
  localparam int AA_DAA  = 9;
  localparam int AA_II   = 10;
  localparam int AA_RR   = 11;
  localparam int AA_INT  = 12;
  localparam int AA_RST  = 13;

  // Encoded source select; 14 and 15 both mean "no source".
  typedef enum logic [3:0] {
    SRC_ONE  = 4'd0,
    SRC_M1   = 4'd1,
    SRC_M2   = 4'd2,
    SRC_HL   = 4'd3,
    SRC_IX   = 4'd4,
    SRC_IY   = 4'd5,
    SRC_PC   = 4'd6,
    SRC_AA   = 4'd7,
    SRC_BIT  = 4'd8,
    SRC_DAA  = 4'd9,
    SRC_II   = 4'd10,
    SRC_RR   = 4'd11,
    SRC_INT  = 4'd12,
    SRC_RST  = 4'd13,
    SRC_NONE = 4'd14
  } alua_src_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PUSH  = 2'd1,
    ST_PCSEL = 2'd2,
    ST_VEC   = 2'd3
  } alua_state_e;

  function automatic logic [ALUA_W-1:0] aa_bit(input int pos);
    return ALUA_W'(1) << pos;
  endfunction

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic multi_hot(input logic [ALUA_W-1:0] v);
    return (v & (v - ALUA_W'(1))) != '0;
  endfunction

endpackage

// File: rtl/alua_dec.sv
// -----------------------------------------------------------------------------
// alua_dec -- purely combinational 4 -> 14 one-hot decoder for the ALU-A
// source select. Encodings 14 and 15 decode to all-zero.
//
// Ports:
//   sel_i     in   4        encoded source select
//   onehot_o  out  ALUA_W   one-hot select, bit n set when sel_i == n
// -----------------------------------------------------------------------------
module alua_dec
  import alua_seq_pkg::*;
(
  input  logic [3:0]        sel_i,
  output logic [ALUA_W-1:0] onehot_o
);

  always_comb begin
    // NOTE: default every output first so no path through the block leaves
    // a bit unassigned; otherwise synthesis infers a latch.
    onehot_o = '0;
    for (int i = 0; i < ALUA_W; i++) begin
      if (sel_i == 4'(i)) onehot_o[i] = 1'b1;
    end
  end

endmodule

// File: rtl/alua_seq.sv
// -----------------------------------------------------------------------------
// alua_seq -- registered ALU-A source select with a built-in interrupt
// vector sequence (push M2, select PC, select INT/RST vector).
//
// Optional feature: define ALUA_CHK_EN to add the sticky sel_err one-hot
// checker and its port. Without it the port and logic are absent.
//
// Ports:
//   clkc      in   1       clock, rising edge
//   reset     in   1       synchronous, active-high reset
//   dec_vld   in   1       decode presents a source select this cycle
//   dec_sel   in   4       encoded source select (see alua_src_e)
//   wait_st   in   1       pipeline stall, freezes all state
//   int_ack   in   1       pulse that starts the interrupt vector sequence
//   rst_op    in   1       sampled with int_ack: 1 = RST vector, 0 = INT vector
//   alua_reg  out  14      registered one-hot ALU-A select
//   seq_busy  out  1       interrupt sequence in progress, decode must hold
//   sel_err   out  1       sticky one-hot violation flag (ALUA_CHK_EN only)
// -----------------------------------------------------------------------------
module alua_seq
  import alua_seq_pkg::*;
(
  input  logic              clkc,
  input  logic              reset,
  input  logic              dec_vld,
  input  logic [3:0]        dec_sel,
  input  logic              wait_st,
  input  logic              int_ack,
  input  logic              rst_op,
  output logic [ALUA_W-1:0] alua_reg,
  output logic              seq_busy
`ifdef ALUA_CHK_EN
  ,
  output logic              sel_err
`endif
);

  alua_state_e       state_q, state_d;
  logic [ALUA_W-1:0] alua_q, alua_d;
  logic              rst_op_q, rst_op_d;
  logic              busy_q;
  logic [ALUA_W-1:0] dec_onehot;
  logic [ALUA_W-1:0] idle_load;

  alua_dec u_dec (
    .sel_i    (dec_sel),
    .onehot_o (dec_onehot)
  );

  // Normal decode load, used in IDLE and on the edge leaving VEC.
  assign idle_load = dec_vld ? dec_onehot : '0;

  always_comb begin
    state_d  = state_q;
    alua_d   = alua_q;
    rst_op_d = rst_op_q;
    if (!wait_st) begin
      unique case (state_q)
        ST_IDLE: begin
          // int_ack wins over a same-cycle decode; decode re-presents later.
          if (int_ack) begin
            state_d  = ST_PUSH;
            alua_d   = aa_bit(AA_M2);
            rst_op_d = rst_op;
          end else begin
            alua_d = idle_load;
          end
        end
        ST_PUSH: begin
          state_d = ST_PCSEL;
          alua_d  = aa_bit(AA_PC);
        end
        ST_PCSEL: begin
          state_d = ST_VEC;
          alua_d  = rst_op_q ? aa_bit(AA_RST) : aa_bit(AA_INT);
        end
        ST_VEC: begin
          // The exit edge behaves as an IDLE cycle without interrupt entry,
          // so a select decode has waited with is picked up here.
          state_d = ST_IDLE;
          alua_d  = idle_load;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

`ifdef ALUA_CHK_EN
  logic sel_err_q;
`endif

  always_ff @(posedge clkc) begin
    // NOTE: reset is synchronous and clears every register, including the
    // sticky error flag, so an aborted sequence restarts from a clean IDLE.
    if (reset) begin
      state_q  <= ST_IDLE;
      alua_q   <= '0;
      rst_op_q <= 1'b0;
      busy_q   <= 1'b0;
`ifdef ALUA_CHK_EN
      sel_err_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q  <= state_d;
      alua_q   <= alua_d;
      rst_op_q <= rst_op_d;
      busy_q   <= (state_d != ST_IDLE);
`ifdef ALUA_CHK_EN
      sel_err_q <= sel_err_q | multi_hot(alua_d);
`endif
    end
  end

  assign alua_reg = alua_q;
  assign seq_busy = busy_q;
`ifdef ALUA_CHK_EN
  assign sel_err  = sel_err_q;
`endif

endmodule

// File: tb/tb_alua_seq.sv
// -----------------------------------------------------------------------------
// tb_alua_seq -- self-checking bench for alua_seq. Directed scenarios plus a
// randomized run checked against a behavioural model that tracks the
// interrupt sequence as a count of remaining steps. Define ALUA_CHK_EN to
// also exercise the sel_err checker.
// -----------------------------------------------------------------------------
module tb_alua_seq;
  import alua_seq_pkg::*;

  logic              clkc = 1'b0;
  logic              reset, dec_vld, wait_st, int_ack, rst_op;
  logic [3:0]        dec_sel;
  logic [ALUA_W-1:0] alua_reg;
  logic              seq_busy;
`ifdef ALUA_CHK_EN
  logic              sel_err;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  alua_seq dut (
    .clkc     (clkc),
    .reset    (reset),
    .dec_vld  (dec_vld),
    .dec_sel  (dec_sel),
    .wait_st  (wait_st),
    .int_ack  (int_ack),
    .rst_op   (rst_op)
    ,
    .alua_reg (alua_reg),
    .seq_busy (seq_busy)
`ifdef ALUA_CHK_EN
    ,
    .sel_err  (sel_err)
`endif
  );

  always #5 clkc = ~clkc;

  // Reference model: m_left counts the sequence steps still to come
  // (3 after int_ack is taken, 0 when idle).
  logic [13:0] m_alua = '0;
  logic        m_busy = 1'b0;
  int          m_left = 0;
  logic        m_vec_rst = 1'b0;

  function automatic logic [13:0] decode_load(input logic vld, input logic [3:0] sel);
    if (vld && sel < 4'd14) return 14'd1 << sel;
    return 14'd0;
  endfunction

  // Update the model from the inputs held across the coming edge, then
  // advance to 1 time unit after that edge.
  task automatic cycle();
    if (reset) begin
      m_alua = '0; m_left = 0; m_vec_rst = 1'b0;
    end else if (!wait_st) begin
      if (m_left == 0) begin
        if (int_ack) begin
          m_left = 3; m_vec_rst = rst_op; m_alua = 14'h0004;
        end else begin
          m_alua = decode_load(dec_vld, dec_sel);
        end
      end else begin
        m_left = m_left - 1;
        case (m_left)
          2:       m_alua = 14'h0040;
          1:       m_alua = m_vec_rst ? 14'h2000 : 14'h1000;
          default: m_alua = decode_load(dec_vld, dec_sel);
        endcase
      end
    end
    m_busy = (m_left != 0);
    @(posedge clkc);
    #1;
  endtask

  task automatic set_idle_inputs();
    reset = 1'b0; dec_vld = 1'b0; dec_sel = 4'd0;
    wait_st = 1'b0; int_ack = 1'b0; rst_op = 1'b0;
  endtask

  task automatic test_reset();
    set_idle_inputs();
    reset = 1'b1; int_ack = 1'b1; wait_st = 1'b1; dec_vld = 1'b1; dec_sel = 4'd3;
    cycle(); cycle();
    n_checks++;
    if (alua_reg !== 14'h0000 || seq_busy !== 1'b0)
      $display("FAIL reset: alua_reg=%h seq_busy=%b, required 0000/0", alua_reg, seq_busy);
    else n_pass++;
    // Reset wins over int_ack: releasing it with int_ack low stays idle.
    set_idle_inputs();
    cycle();
    n_checks++;
    if (seq_busy !== 1'b0)
      $display("FAIL reset_priority: seq_busy=%b, required 0", seq_busy);
    else n_pass++;
  endtask

  task automatic test_decode();
    set_idle_inputs();
    dec_vld = 1'b1; dec_sel = 4'd3;
    cycle();
    n_checks++;
    if (alua_reg !== 14'h0008 || seq_busy !== 1'b0)
      $display("FAIL decode_hl: alua_reg=%h seq_busy=%b, required 0008/0", alua_reg, seq_busy);
    else n_pass++;
    for (int s = 0; s < 16; s++) begin
      dec_vld = 1'b1; dec_sel = 4'(s);
      cycle();
      n_checks++;
      if (alua_reg !== m_alua)
        $display("FAIL decode_sel%0d: alua_reg=%h, required %h", s, alua_reg, m_alua);
      else n_pass++;
    end
    dec_vld = 1'b0; dec_sel = 4'd5;
    cycle();
    n_checks++;
    if (alua_reg !== 14'h0000)
      $display("FAIL decode_novld: alua_reg=%h, required 0000", alua_reg);
    else n_pass++;
  endtask

  task automatic test_stall();
    set_idle_inputs();
    dec_vld = 1'b1; dec_sel = 4'd4;
    cycle();
    n_checks++;
    if (alua_reg !== 14'h0010)
      $display("FAIL stall_issue: alua_reg=%h, required 0010", alua_reg);
    else n_pass++;
    wait_st = 1'b1; dec_sel = 4'd5; int_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++;
      if (alua_reg !== 14'h0010 || seq_busy !== 1'b0)
        $display("FAIL stall_hold%0d: alua_reg=%h seq_busy=%b, required 0010/0", i, alua_reg, seq_busy);
      else n_pass++;
    end
    wait_st = 1'b0; int_ack = 1'b0;
    cycle();
    n_checks++;
    if (alua_reg !== 14'h0020)
      $display("FAIL stall_release: alua_reg=%h, required 0020", alua_reg);
    else n_pass++;
  endtask

  task automatic test_int_seq();
    logic [13:0] exp_seq [3] = '{14'h0004, 14'h0040, 14'h1000};
    set_idle_inputs();
    int_ack = 1'b1; rst_op = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      // Stray int_ack/decode while busy must be ignored; drop both before exit.
      int_ack = (i == 0); dec_vld = (i == 0); dec_sel = 4'd1; rst_op = 1'b1;
      if (i == 1) begin int_ack = 1'b0; dec_vld = 1'b0; end
      n_checks++;
      if (alua_reg !== exp_seq[i] || seq_busy !== 1'b1)
        $display("FAIL int_seq%0d: alua_reg=%h seq_busy=%b, required %h/1", i, alua_reg, seq_busy, exp_seq[i]);
      else n_pass++;
    end
    cycle();
    n_checks++;
    if (alua_reg !== 14'h0000 || seq_busy !== 1'b0)
      $display("FAIL int_seq_end: alua_reg=%h seq_busy=%b, required 0000/0", alua_reg, seq_busy);
    else n_pass++;
  endtask

  task automatic test_rst_collision();
    logic seen_aa = 1'b0;
    set_idle_inputs();
    int_ack = 1'b1; rst_op = 1'b1; dec_vld = 1'b1; dec_sel = 4'd7;
    cycle();
    if (alua_reg === 14'h0080) seen_aa = 1'b1;
    set_idle_inputs();
    n_checks++;
    if (alua_reg !== 14'h0004)
      $display("FAIL coll_push: alua_reg=%h, required 0004", alua_reg);
    else n_pass++;
    cycle();
    if (alua_reg === 14'h0080) seen_aa = 1'b1;
    cycle();
    if (alua_reg === 14'h0080) seen_aa = 1'b1;
    n_checks++;
    if (alua_reg !== 14'h2000)
      $display("FAIL coll_vec: alua_reg=%h, required 2000", alua_reg);
    else n_pass++;
    cycle();
    if (alua_reg === 14'h0080) seen_aa = 1'b1;
    n_checks++;
    if (seen_aa !== 1'b0)
      $display("FAIL coll_dropped: AA select seen=%b, required 0", seen_aa);
    else n_pass++;
  endtask

  task automatic test_abort();
    set_idle_inputs();
    int_ack = 1'b1;
    cycle();
    int_ack = 1'b0;
    cycle();   // now in PCSEL
    n_checks++;
    if (alua_reg !== 14'h0040)
      $display("FAIL abort_pcsel: alua_reg=%h, required 0040", alua_reg);
    else n_pass++;
    reset = 1'b1; wait_st = 1'b1;
    cycle();
    n_checks++;
    if (alua_reg !== 14'h0000 || seq_busy !== 1'b0)
      $display("FAIL abort_reset: alua_reg=%h seq_busy=%b, required 0000/0", alua_reg, seq_busy);
    else n_pass++;
    set_idle_inputs();
    int_ack = 1'b1;
    cycle();
    int_ack = 1'b0;
    n_checks++;
    if (alua_reg !== 14'h0004 || seq_busy !== 1'b1)
      $display("FAIL abort_restart: alua_reg=%h seq_busy=%b, required 0004/1", alua_reg, seq_busy);
    else n_pass++;
    cycle(); cycle(); cycle();
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 600; i++) begin
      reset   = ($urandom_range(0, 39) == 0);
      wait_st = ($urandom_range(0, 3) == 0);
      int_ack = ($urandom_range(0, 5) == 0);
      rst_op  = 1'($urandom);
      dec_vld = 1'($urandom);
      dec_sel = 4'($urandom);
      cycle();
      n_checks++;
      if (alua_reg !== m_alua || seq_busy !== m_busy) begin
        errs++;
        if (errs <= 10)
          $display("FAIL random%0d: alua_reg=%h seq_busy=%b, required %h/%b",
                   i, alua_reg, seq_busy, m_alua, m_busy);
      end else n_pass++;
      n_checks++;
      if (!$onehot0(alua_reg))
        $display("FAIL random_onehot%0d: alua_reg=%h, required at most one bit", i, alua_reg);
      else n_pass++;
`ifdef ALUA_CHK_EN
      n_checks++;
      if (sel_err !== 1'b0)
        $display("FAIL random_sel_err%0d: sel_err=%b, required 0", i, sel_err);
      else n_pass++;
`endif
    end
    set_idle_inputs();
    cycle(); cycle(); cycle(); cycle();
  endtask

`ifdef ALUA_CHK_EN
  task automatic test_checker();
    set_idle_inputs();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    n_checks++;
    if (sel_err !== 1'b0)
      $display("FAIL chk_clear: sel_err=%b, required 0", sel_err);
    else n_pass++;
    force dut.alua_d = 14'h0003;
    cycle();
    release dut.alua_d;
    dec_vld = 1'b1; dec_sel = 4'd1;
    n_checks++;
    if (sel_err !== 1'b1)
      $display("FAIL chk_set: sel_err=%b, required 1", sel_err);
    else n_pass++;
    cycle();
    dec_vld = 1'b0;
    cycle(); cycle();
    n_checks++;
    if (sel_err !== 1'b1)
      $display("FAIL chk_sticky: sel_err=%b, required 1", sel_err);
    else n_pass++;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    n_checks++;
    if (sel_err !== 1'b0)
      $display("FAIL chk_reset: sel_err=%b, required 0", sel_err);
    else n_pass++;
  endtask
`endif

  initial begin
    set_idle_inputs();
    reset = 1'b1;
    test_reset();
    test_decode();
    test_stall();
    test_int_seq();
    test_rst_collision();
    test_abort();
    test_random();
`ifdef ALUA_CHK_EN
    test_checker();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
